// File: rtl/bp_table_ctrl.sv
// Branch predictor pattern table controller: 2-bit saturating counters with a single
// access slot shared by fetch lookups and buffered execute-stage updates.
module bp_table_ctrl #(
   parameter int         IDX_W     = 4,
   parameter int         UQ_DEPTH  = 2,
   parameter logic [1:0] RESET_CNT = 2'b11
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clr,
   input  logic                            lk_valid,
   input  logic [IDX_W-1:0]                lk_idx,
   output logic                            lk_ready,
   output logic                            resp_valid,
   output logic                            resp_pred,
   output logic [1:0]                      resp_cnt,
   output logic [IDX_W-1:0]                resp_idx,
   input  logic                            up_valid,
   input  logic [IDX_W-1:0]                up_idx,
   input  logic                            up_taken,
   output logic                            up_ready,
   output logic                            busy,
   output logic [$clog2(UQ_DEPTH+1)-1:0]   uq_count
);
   localparam int ENTRIES = 1 << IDX_W;
   localparam int CW      = $clog2(UQ_DEPTH + 1);
   localparam int PW      = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;

   typedef enum logic {RUN, CLEAR} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] sweep_q, sweep_nx;
   logic [1:0]       cnt_q [ENTRIES];

   logic [IDX_W-1:0] fq_idx   [UQ_DEPTH];
   logic             fq_taken [UQ_DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;

   logic             full, empty, lk_grant, enq, drain, flush, we;
   logic [IDX_W-1:0] head_idx, widx;
   logic [1:0]       head_old, head_new, wdata;

   assign full     = (count == CW'(UQ_DEPTH));
   assign empty    = (count == '0);
   assign head_idx = fq_idx[rd_ptr];
   assign head_old = cnt_q[head_idx];

   always_comb begin
      head_new = head_old;
      if (fq_taken[rd_ptr]) begin
         if (head_old != 2'b11) head_new = head_old + 2'b01;
      end else begin
         if (head_old != 2'b00) head_new = head_old - 2'b01;
      end
   end

   // Readies are gated by rst so they read 0 for the whole reset window.
   assign lk_ready = (state == RUN) && !clr && !full && !rst;
   assign up_ready = (state == RUN) && !clr && !full && !rst;
   assign lk_grant = lk_valid && lk_ready;
   assign enq      = up_valid && up_ready;
   assign busy     = (state == CLEAR);
   assign uq_count = count;

   always_comb begin
      state_nx = state;
      sweep_nx = sweep_q;
      drain    = 1'b0;
      flush    = 1'b0;
      we       = 1'b0;
      widx     = head_idx;
      wdata    = head_new;
      case (state)
         RUN: begin
            if (clr) begin
               state_nx = CLEAR;
               sweep_nx = '0;
               flush    = 1'b1;
            end else if (full || (!lk_valid && !empty)) begin
               drain = 1'b1;
               we    = 1'b1;
            end
         end
         CLEAR: begin
            we    = 1'b1;
            widx  = sweep_q;
            wdata = RESET_CNT;
            if (clr) begin
               sweep_nx = '0;
               flush    = 1'b1;
            end else if (&sweep_q) begin
               state_nx = RUN;
            end else begin
               sweep_nx = sweep_q + 1'b1;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         sweep_q <= '0;
      end else begin
         state   <= state_nx;
         sweep_q <= sweep_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= RESET_CNT;
      end else if (we) begin
         cnt_q[widx] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fq_idx[wr_ptr]   <= up_idx;
         fq_taken[wr_ptr] <= up_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq)   wr_ptr <= (wr_ptr == PW'(UQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (drain) rd_ptr <= (rd_ptr == PW'(UQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({enq, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Response fields hold between lookups; only resp_valid pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_pred  <= 1'b0;
         resp_cnt   <= 2'b00;
         resp_idx   <= '0;
      end else begin
         resp_valid <= lk_grant;
         if (lk_grant) begin
            resp_cnt  <= cnt_q[lk_idx];
            resp_pred <= cnt_q[lk_idx][1];
            resp_idx  <= lk_idx;
         end
      end
   end
endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl: lookups, saturating updates, forced drains,
// clear sweep and asynchronous reset, with hand-computed expectations.
module tb_bp_table_ctrl;
   logic       clk, rst, clr, lk_valid, up_valid, up_taken;
   logic [3:0] lk_idx, up_idx, resp_idx;
   logic       lk_ready, resp_valid, resp_pred, up_ready, busy;
   logic [1:0] resp_cnt, uq_count;
   int         n_cmp = 0;
   int         n_err = 0;

   bp_table_ctrl #(.IDX_W(4), .UQ_DEPTH(2), .RESET_CNT(2'b11)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
      .resp_valid(resp_valid), .resp_pred(resp_pred), .resp_cnt(resp_cnt), .resp_idx(resp_idx),
      .up_valid(up_valid), .up_idx(up_idx), .up_taken(up_taken), .up_ready(up_ready),
      .busy(busy), .uq_count(uq_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [3:0] idx);
      lk_valid = 1'b1;
      lk_idx   = idx;
      cyc();
      lk_valid = 1'b0;
   endtask

   task automatic push_update(input logic [3:0] idx, input logic taken);
      up_valid = 1'b1;
      up_idx   = idx;
      up_taken = taken;
      @(negedge clk);
      n_cmp++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL push_up_ready got %b want 1", up_ready); end
      cyc();
      up_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; lk_valid = 1'b0; lk_idx = '0;
      up_valid = 1'b0; up_idx = '0; up_taken = 1'b0;
      @(negedge clk);
      n_cmp++; if (lk_ready !== 1'b0)   begin n_err++; $display("FAIL rst_lk_ready got %b want 0", lk_ready); end
      n_cmp++; if (up_ready !== 1'b0)   begin n_err++; $display("FAIL rst_up_ready got %b want 0", up_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
      n_cmp++; if (resp_cnt !== 2'b00)  begin n_err++; $display("FAIL rst_resp_cnt got %b want 00", resp_cnt); end
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (uq_count !== 2'd0)   begin n_err++; $display("FAIL rst_uq_count got %0d want 0", uq_count); end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (lk_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_lk_ready got %b want 1", lk_ready); end
      n_cmp++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_up_ready got %b want 1", up_ready); end
      cyc();
   endtask

   task automatic test_lookup();
      lookup(4'd5);
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL lk5_valid got %b want 1", resp_valid); end
      n_cmp++; if (resp_idx !== 4'd5)   begin n_err++; $display("FAIL lk5_idx got %0d want 5", resp_idx); end
      n_cmp++; if (resp_cnt !== 2'b11)  begin n_err++; $display("FAIL lk5_cnt got %b want 11", resp_cnt); end
      n_cmp++; if (resp_pred !== 1'b1)  begin n_err++; $display("FAIL lk5_pred got %b want 1", resp_pred); end
      cyc();
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL lk5_pulse got %b want 0", resp_valid); end
      n_cmp++; if (resp_idx !== 4'd5)   begin n_err++; $display("FAIL lk5_hold got %0d want 5", resp_idx); end
      cyc();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 4; i++) push_update(4'd3, 1'b0);
      cyc();
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd0) begin n_err++; $display("FAIL sat_drained got %0d want 0", uq_count); end
      cyc();
      lookup(4'd3);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b00) begin n_err++; $display("FAIL sat_low_cnt got %b want 00", resp_cnt); end
      n_cmp++; if (resp_pred !== 1'b0) begin n_err++; $display("FAIL sat_low_pred got %b want 0", resp_pred); end
      cyc();
      push_update(4'd3, 1'b0);
      cyc();
      lookup(4'd3);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b00) begin n_err++; $display("FAIL sat_floor_cnt got %b want 00", resp_cnt); end
      cyc();
      push_update(4'd3, 1'b1);
      push_update(4'd3, 1'b1);
      cyc();
      lookup(4'd3);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b10) begin n_err++; $display("FAIL sat_up_cnt got %b want 10", resp_cnt); end
      n_cmp++; if (resp_pred !== 1'b1) begin n_err++; $display("FAIL sat_up_pred got %b want 1", resp_pred); end
      cyc();
   endtask

   task automatic test_back_to_back();
      lk_valid = 1'b1; lk_idx = 4'd9;
      up_valid = 1'b1; up_idx = 4'd1; up_taken = 1'b0;
      @(negedge clk);
      n_cmp++; if (lk_ready !== 1'b1) begin n_err++; $display("FAIL b2b_a_lk_ready got %b want 1", lk_ready); end
      cyc();
      up_idx = 4'd2;
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd1) begin n_err++; $display("FAIL b2b_b_count got %0d want 1", uq_count); end
      n_cmp++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL b2b_b_up_ready got %b want 1", up_ready); end
      cyc();
      up_idx = 4'd1;
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd2) begin n_err++; $display("FAIL b2b_c_count got %0d want 2", uq_count); end
      n_cmp++; if (lk_ready !== 1'b0) begin n_err++; $display("FAIL b2b_c_lk_ready got %b want 0", lk_ready); end
      n_cmp++; if (up_ready !== 1'b0) begin n_err++; $display("FAIL b2b_c_up_ready got %b want 0", up_ready); end
      cyc();
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd1) begin n_err++; $display("FAIL b2b_d_count got %0d want 1", uq_count); end
      n_cmp++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL b2b_d_up_ready got %b want 1", up_ready); end
      n_cmp++; if (lk_ready !== 1'b1) begin n_err++; $display("FAIL b2b_d_lk_ready got %b want 1", lk_ready); end
      cyc();
      up_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd2) begin n_err++; $display("FAIL b2b_e_count got %0d want 2", uq_count); end
      n_cmp++; if (lk_ready !== 1'b0) begin n_err++; $display("FAIL b2b_e_lk_ready got %b want 0", lk_ready); end
      cyc();
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd1)   begin n_err++; $display("FAIL b2b_f_count got %0d want 1", uq_count); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_f_resp_valid got %b want 0", resp_valid); end
      cyc();
      lk_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_g_resp_valid got %b want 1", resp_valid); end
      cyc();
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd0) begin n_err++; $display("FAIL b2b_h_count got %0d want 0", uq_count); end
      cyc();
      lookup(4'd1);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b01) begin n_err++; $display("FAIL b2b_idx1_cnt got %b want 01", resp_cnt); end
      cyc();
      lookup(4'd2);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b10) begin n_err++; $display("FAIL b2b_idx2_cnt got %b want 10", resp_cnt); end
      cyc();
   endtask

   task automatic test_stale();
      lk_valid = 1'b1; lk_idx = 4'd7;
      up_valid = 1'b1; up_idx = 4'd7; up_taken = 1'b0;
      cyc();
      lk_valid = 1'b0; up_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b11) begin n_err++; $display("FAIL stale_cnt got %b want 11", resp_cnt); end
      n_cmp++; if (uq_count !== 2'd1)  begin n_err++; $display("FAIL stale_count got %0d want 1", uq_count); end
      cyc();
      lookup(4'd7);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b10) begin n_err++; $display("FAIL fresh_cnt got %b want 10", resp_cnt); end
      cyc();
   endtask

   task automatic test_clear();
      push_update(4'd0, 1'b0);
      push_update(4'd0, 1'b0);
      push_update(4'd15, 1'b0);
      push_update(4'd15, 1'b0);
      cyc();
      cyc();
      lookup(4'd0);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b01) begin n_err++; $display("FAIL clr_pre_idx0 got %b want 01", resp_cnt); end
      cyc();
      lk_valid = 1'b1; lk_idx = 4'd4;
      up_valid = 1'b1; up_idx = 4'd0; up_taken = 1'b0;
      cyc();
      up_idx = 4'd15;
      cyc();
      lk_valid = 1'b0; up_valid = 1'b0; clr = 1'b1;
      @(negedge clk);
      n_cmp++; if (uq_count !== 2'd2)   begin n_err++; $display("FAIL clr_queued got %0d want 2", uq_count); end
      n_cmp++; if (lk_ready !== 1'b0)   begin n_err++; $display("FAIL clr_lk_ready got %b want 0", lk_ready); end
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL clr_prior_resp got %b want 1", resp_valid); end
      n_cmp++; if (resp_idx !== 4'd4)   begin n_err++; $display("FAIL clr_prior_idx got %0d want 4", resp_idx); end
      cyc();
      clr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL sweep%0d_busy got %b want 1", i, busy); end
         n_cmp++; if (lk_ready !== 1'b0) begin n_err++; $display("FAIL sweep%0d_lk_ready got %b want 0", i, lk_ready); end
         n_cmp++; if (up_ready !== 1'b0) begin n_err++; $display("FAIL sweep%0d_up_ready got %b want 0", i, up_ready); end
         n_cmp++; if (uq_count !== 2'd0) begin n_err++; $display("FAIL sweep%0d_count got %0d want 0", i, uq_count); end
         cyc();
      end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL clr_done_busy got %b want 0", busy); end
      n_cmp++; if (lk_ready !== 1'b1) begin n_err++; $display("FAIL clr_done_lk_ready got %b want 1", lk_ready); end
      cyc();
      lookup(4'd0);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b11) begin n_err++; $display("FAIL clr_idx0 got %b want 11", resp_cnt); end
      cyc();
      lookup(4'd15);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b11) begin n_err++; $display("FAIL clr_idx15 got %b want 11", resp_cnt); end
      cyc();
   endtask

   task automatic test_reset_mid_op();
      push_update(4'd14, 1'b0);
      cyc();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      repeat (5) cyc();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rclr_busy got %b want 0", busy); end
      n_cmp++; if (lk_ready !== 1'b0) begin n_err++; $display("FAIL rclr_lk_ready got %b want 0", lk_ready); end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (lk_ready !== 1'b1) begin n_err++; $display("FAIL rclr_run got %b want 1", lk_ready); end
      cyc();
      lookup(4'd14);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b11) begin n_err++; $display("FAIL rclr_idx14 got %b want 11", resp_cnt); end
      cyc();
      lk_valid = 1'b1; lk_idx = 4'd6;
      up_valid = 1'b1; up_idx = 4'd6; up_taken = 1'b0;
      cyc();
      cyc();
      lk_valid = 1'b0; up_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rdrn_resp_valid got %b want 0", resp_valid); end
      n_cmp++; if (resp_idx !== 4'd0)   begin n_err++; $display("FAIL rdrn_resp_idx got %0d want 0", resp_idx); end
      n_cmp++; if (resp_cnt !== 2'b00)  begin n_err++; $display("FAIL rdrn_resp_cnt got %b want 00", resp_cnt); end
      n_cmp++; if (uq_count !== 2'd0)   begin n_err++; $display("FAIL rdrn_count got %0d want 0", uq_count); end
      n_cmp++; if (up_ready !== 1'b0)   begin n_err++; $display("FAIL rdrn_up_ready got %b want 0", up_ready); end
      cyc();
      rst = 1'b0;
      cyc();
      lookup(4'd6);
      @(negedge clk);
      n_cmp++; if (resp_cnt !== 2'b11) begin n_err++; $display("FAIL rdrn_idx6 got %b want 11", resp_cnt); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_lookup();
      test_saturate();
      test_back_to_back();
      test_stale();
      test_clear();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
